// File: rtl/uart_rx_fill_if.sv
// uart_rx_fill_if -- byte-FIFO write port used by the UART receiver.
//   wr   : single-cycle push strobe (receiver -> FIFO)
//   din  : received byte, valid while wr=1 and held until the next push
//   full : FIFO full flag (FIFO -> receiver)
// master = receiver side, slave = FIFO side.
interface uart_rx_fill_if;
    logic       wr;
    logic [7:0] din;
    logic       full;

    modport master (output wr, output din, input full);
    modport slave  (input wr, input din, output full);
endinterface

// File: rtl/uart_rx_fill.sv
// uart_rx_fill -- 8N1 UART receiver that pushes each good byte into a byte FIFO.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   rx        : asynchronous serial line, idle high, LSB first
//   err_clr   : synchronous clear of the sticky error flags
//   overrun   : sticky, a good byte was dropped because the FIFO was full
//   frame_err : sticky, a stop bit was sampled low
//   busy      : high whenever the receiver is not idle
//   fifo      : FIFO write port (wr, din out; full in)
module uart_rx_fill #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx,
    input  logic           err_clr,
    output logic           overrun,
    output logic           frame_err,
    output logic           busy,
    uart_rx_fill_if.master fifo
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StBrk   = 3'd4;

    logic            r_sync1;
    logic            r_sync2;
    logic [1:0]      r_warm;
    logic            r_armed;
    logic [2:0]      r_state;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_bitn;
    logic [7:0]      r_shift;
    logic            r_wr;
    logic [7:0]      r_din;
    logic            r_overrun;
    logic            r_frame_err;

    logic            w_rx_s;
    logic [2:0]      w_state_d;
    logic [CntW-1:0] w_cnt_d;
    logic [2:0]      w_bitn_d;
    logic [7:0]      w_shift_d;
    logic            w_armed_d;
    logic            w_wr_d;
    logic [7:0]      w_din_d;
    logic            w_ovr_set;
    logic            w_fe_set;

    assign w_rx_s = r_sync2;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 1'b1;
        w_bitn_d  = r_bitn;
        w_shift_d = r_shift;
        w_armed_d = 1'b0;
        w_wr_d    = 1'b0;
        w_din_d   = r_din;
        w_ovr_set = 1'b0;
        w_fe_set  = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                // The synchronizer resets to 1, so its first two outputs after
                // reset are not real line samples; r_warm masks them so a line
                // held low through reset cannot arm the receiver.
                w_armed_d = r_armed | (r_warm[1] & w_rx_s);
                if (r_armed && !w_rx_s) begin
                    w_state_d = StStart;
                    w_armed_d = 1'b0;
                end
            end
            StStart: begin
                if (r_cnt == CntHalf) begin
                    w_cnt_d  = '0;
                    w_bitn_d = 3'd0;
                    w_state_d = w_rx_s ? StIdle : StData;
                end
            end
            StData: begin
                if (r_cnt == CntLast) begin
                    w_cnt_d   = '0;
                    w_shift_d = {w_rx_s, r_shift[7:1]};
                    w_bitn_d  = r_bitn + 3'd1;
                    if (r_bitn == 3'd7) begin
                        w_state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (r_cnt == CntLast) begin
                    w_cnt_d = '0;
                    if (w_rx_s) begin
                        w_state_d = StIdle;
                        // full only matters in this cycle
                        if (fifo.full) begin
                            w_ovr_set = 1'b1;
                        end else begin
                            w_wr_d  = 1'b1;
                            w_din_d = r_shift;
                        end
                    end else begin
                        w_fe_set  = 1'b1;
                        w_state_d = StBrk;
                    end
                end
            end
            StBrk: begin
                w_cnt_d = '0;
                if (w_rx_s) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_warm      <= 2'b00;
            r_armed     <= 1'b0;
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bitn      <= 3'd0;
            r_shift     <= 8'h00;
            r_wr        <= 1'b0;
            r_din       <= 8'h00;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_warm      <= {r_warm[0], 1'b1};
            r_armed     <= w_armed_d;
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_bitn      <= w_bitn_d;
            r_shift     <= w_shift_d;
            r_wr        <= w_wr_d;
            r_din       <= w_din_d;
            // A new error event wins over a simultaneous clear.
            r_overrun   <= w_ovr_set | (r_overrun & ~err_clr);
            r_frame_err <= w_fe_set | (r_frame_err & ~err_clr);
        end
    end

    assign fifo.wr   = r_wr;
    assign fifo.din  = r_din;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_fill.sv
// tb_uart_rx_fill -- self-checking bench for uart_rx_fill.
// Frames are described to an event model (start cycle, byte, stop bit); the
// model derives when wr / flags / busy must appear from the frame timing rules.
module tb_uart_rx_fill;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
    localparam int Big = 32'h7fffffff;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic rx      = 1'b1;
    logic err_clr = 1'b0;
    logic overrun;
    logic frame_err;
    logic busy;

    uart_rx_fill_if fifo ();

    uart_rx_fill #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .err_clr   (err_clr),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy),
        .fifo      (fifo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Values the DUT saw at the most recent edge.
    logic full_prev = 1'b0;
    logic clr_prev  = 1'b0;
    always @(posedge clk) begin
        full_prev <= fifo.full;
        clr_prev  <= err_clr;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int         t0;
        int         endc;
        logic [7:0] data;
        bit         stop_ok;
        bit         glitch;
    } frame_t;

    frame_t     fq[$];
    logic       m_ovr = 1'b0;
    logic       m_fe  = 1'b0;
    logic [7:0] m_din = 8'h00;

    // Model + per-cycle compare.
    initial begin : cmp_proc
        logic ew, eb, so, sf;
        forever begin
            @(negedge clk);
            ew = 1'b0; eb = 1'b0; so = 1'b0; sf = 1'b0;
            if (rst) begin
                m_ovr = 1'b0;
                m_fe  = 1'b0;
                m_din = 8'h00;
                fq.delete();
            end else begin
                foreach (fq[i]) begin
                    if (!fq[i].glitch && cyc == fq[i].t0 + 3 + H + 9 * CPB) begin
                        if (!fq[i].stop_ok) sf = 1'b1;
                        else if (full_prev) so = 1'b1;
                        else begin
                            ew    = 1'b1;
                            m_din = fq[i].data;
                        end
                    end
                    if (cyc >= fq[i].t0 + 3 && cyc < fq[i].endc) eb = 1'b1;
                end
                if (so) m_ovr = 1'b1;
                else if (clr_prev) m_ovr = 1'b0;
                if (sf) m_fe = 1'b1;
                else if (clr_prev) m_fe = 1'b0;
                while (fq.size() > 0 && fq[0].endc < cyc) fq.delete(0);
            end
            chk("wr", 32'(fifo.wr), 32'(ew));
            chk("din", 32'(fifo.din), 32'(m_din));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
            chk("busy", 32'(busy), 32'(eb));
        end
    end

    // Write monitor used by the literal checks.
    int         wr_cnt      = 0;
    int         last_wr_cyc = 0;
    logic       busy_at_wr  = 1'b1;
    logic [7:0] wr_log[$];
    initial begin
        forever begin
            @(negedge clk);
            if (fifo.wr === 1'b1) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                busy_at_wr  = busy;
                wr_log.push_back(fifo.din);
            end
        end
    end

    // Random full / err_clr while rand_mode is set.
    bit rand_mode = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) begin
                fifo.full = ($urandom_range(0, 1) == 1);
                err_clr   = ($urandom_range(0, 15) == 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int brk_hold,
                              output int t0);
        frame_t f;
        t0 = cyc;
        rx = 1'b0;
        f.t0 = t0; f.data = b; f.stop_ok = stop_ok; f.glitch = 1'b0;
        f.endc = stop_ok ? t0 + 3 + H + 9 * CPB : Big;
        fq.push_back(f);
        for (int i = 0; i < 8; i++) begin
            idle(CPB);
            rx = b[i];
        end
        idle(CPB);
        rx = stop_ok;
        idle(CPB);
        if (!stop_ok) begin
            idle(brk_hold);
            rx = 1'b1;
            if (fq.size() > 0) fq[fq.size() - 1].endc = cyc + 3;
        end
    endtask

    task automatic send_glitch(input int len);
        frame_t f;
        f.t0 = cyc; f.data = 8'h00; f.stop_ok = 1'b1; f.glitch = 1'b1;
        f.endc = cyc + 3 + H;
        fq.push_back(f);
        rx = 1'b0;
        idle(len);
        rx = 1'b1;
    endtask

    // Start a frame, reset in the middle of data bit 4.
    task automatic send_aborted(input logic [7:0] b);
        frame_t f;
        f.t0 = cyc; f.data = b; f.stop_ok = 1'b1; f.glitch = 1'b0;
        f.endc = cyc + 3 + H + 9 * CPB;
        fq.push_back(f);
        rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(CPB);
            rx = b[i];
        end
        idle(H);
        rst = 1'b1;
        rx  = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    int t0;
    int w0;
    int n;
    logic [7:0] rb;
    bit ok;
    int hold;
    int gap;

    initial begin
        fifo.full = 1'b0;
        idle(4);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_din", 32'(fifo.din), 0);
        chk("rst_wr", 32'(fifo.wr), 0);
        chk("rst_flags", 32'({overrun, frame_err}), 0);
        rst = 1'b0;
        idle(10);

        // Single byte, latency pin.
        w0 = wr_cnt;
        send_frame(8'hA5, 1'b1, 0, t0);
        idle(10);
        chk("a5_count", wr_cnt - w0, 1);
        chk("a5_latency", last_wr_cyc - t0, 155);
        chk("a5_din", 32'(fifo.din), 32'h0000_00A5);
        chk("a5_busy_after", 32'(busy_at_wr), 0);

        // Back-to-back frames with a single stop bit.
        w0 = wr_cnt;
        send_frame(8'h00, 1'b1, 0, t0);
        send_frame(8'hFF, 1'b1, 0, t0);
        send_frame(8'h3C, 1'b1, 0, t0);
        idle(20);
        n = wr_log.size();
        chk("b2b_count", wr_cnt - w0, 3);
        chk("b2b_d0", 32'(wr_log[n-3]), 32'h00);
        chk("b2b_d1", 32'(wr_log[n-2]), 32'hFF);
        chk("b2b_d2", 32'(wr_log[n-1]), 32'h3C);
        chk("b2b_flags", 32'({overrun, frame_err}), 0);

        // Overrun, then clear.
        w0 = wr_cnt;
        fifo.full = 1'b1;
        send_frame(8'h5A, 1'b1, 0, t0);
        fifo.full = 1'b0;
        idle(5);
        chk("ovr_count", wr_cnt - w0, 0);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_din", 32'(fifo.din), 32'h3C);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(2);
        chk("ovr_clr", 32'(overrun), 0);

        // Framing error and break.
        w0 = wr_cnt;
        send_frame(8'h81, 1'b0, 40, t0);
        idle(10);
        chk("fe_count", wr_cnt - w0, 0);
        chk("fe_flag", 32'(frame_err), 1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        idle(3);
        chk("fe_clr", 32'(frame_err), 0);

        // Start-bit glitch.
        w0 = wr_cnt;
        send_glitch(5);
        idle(30);
        chk("gl_count", wr_cnt - w0, 0);
        chk("gl_flags", 32'({overrun, frame_err}), 0);

        // Reset mid-frame, then a clean frame.
        w0 = wr_cnt;
        send_aborted(8'h96);
        idle(30);
        chk("abort_count", wr_cnt - w0, 0);
        send_frame(8'hC3, 1'b1, 0, t0);
        idle(10);
        chk("c3_count", wr_cnt - w0, 1);
        chk("c3_din", 32'(fifo.din), 32'hC3);

        // Reset released with the line low: no start until it goes high.
        rx  = 1'b0;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        w0 = wr_cnt;
        idle(30);
        chk("lowrst_busy", 32'(busy), 0);
        rx = 1'b1;
        idle(10);
        send_frame(8'h69, 1'b1, 0, t0);
        idle(10);
        chk("lowrst_count", wr_cnt - w0, 1);
        chk("lowrst_din", 32'(fifo.din), 32'h69);

        // Randomized frames, random full and err_clr.
        rand_mode = 1'b1;
        for (int k = 0; k < 30; k++) begin
            rb   = 8'($urandom);
            ok   = ($urandom_range(0, 4) != 0);
            hold = $urandom_range(0, 30);
            send_frame(rb, ok, hold, t0);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, 25);
            if (!ok && gap < 3) gap = 3;
            idle(gap);
        end
        rand_mode = 1'b0;
        idle(2);
        fifo.full = 1'b0;
        err_clr   = 1'b0;
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fill.md
UART_RX_FILL -- requirements
Module: uart_rx_fill

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 16, clk cycles per UART bit; it SHALL be even and >= 4.
REQ-002 The block SHALL have port clk, input, 1, clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; it SHALL be asynchronous and active-high.
REQ-004 The block SHALL have port rx, input, 1, asynchronous serial line: idle high, 8N1 framing, LSB first.
REQ-005 The block SHALL have port full, input, 1, downstream byte-FIFO full flag.
REQ-006 The block SHALL have port wr, output, 1, single-cycle write strobe to the FIFO.
REQ-007 The block SHALL have port din, output, 8, received byte; it SHALL be valid while wr=1 and held until the next push.
REQ-008 The block SHALL have port err_clr, input, 1, synchronous clear of the sticky error flags.
REQ-009 The block SHALL have port overrun, output, 1, sticky flag: a good byte was dropped because full=1.
REQ-010 The block SHALL have port frame_err, output, 1, sticky flag: the stop bit was sampled low.
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer, giving rx_s; the synchronizer flops SHALL reset to 1.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and BRK.
REQ-014 IDLE SHALL be armed only after rx_s=1 has been seen since entering IDLE; an armed IDLE with rx_s=0 SHALL move to START and clear the bit counter.
REQ-015 START SHALL sample rx_s when the bit counter reaches CLKS_PER_BIT/2-1; rx_s=1 SHALL be a glitch and return to IDLE with no flags set, and rx_s=0 SHALL move to DATA.
REQ-016 DATA SHALL sample rx_s every CLKS_PER_BIT cycles, 8 times, shifting LSB first; it SHALL move to STOP after the 8th sample.
REQ-017 STOP SHALL sample rx_s after CLKS_PER_BIT cycles, which is mid-stop-bit.
REQ-018 In STOP, rx_s=1 with full=0 SHALL load din with the byte, pulse wr for exactly one cycle, and return to IDLE.
REQ-019 In STOP, rx_s=1 with full=1 SHALL produce no wr, leave din unchanged, set overrun, and return to IDLE.
REQ-020 In STOP, rx_s=0 SHALL produce no wr, set frame_err, and enter BRK.
REQ-021 BRK SHALL wait for rx_s=1, then go to IDLE.
REQ-022 full SHALL be sampled only in the stop-sample cycle.
REQ-023 Latency: with t0 the first clk edge at which rx=0, wr SHALL be high in the cycle following edge t0+3+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
REQ-024 The bit counter width SHALL be $clog2(CLKS_PER_BIT); the counter SHALL wrap to 0 at each sample point with no drift.
REQ-025 When err_clr and a new error event occur in the same cycle, the flag SHALL be set, not cleared.
REQ-026 The block SHALL never assert wr on two consecutive cycles.
REQ-027 The block SHALL never assert wr while full=1 is being sampled.
REQ-028 A start bit arriving during STOP SHALL be ignored until the block is back in IDLE; back-to-back frames with a one-bit stop SHALL be received without loss.

Reset
REQ-029 While rst=1: FSM SHALL be in IDLE (unarmed); wr=0, din=8'h00, overrun=0, frame_err=0, busy=0; counters and shift register SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial byte with no wr.
REQ-031 After reset deasserts with rx low, the block SHALL wait for rx high before detecting any start bit.

Verification
REQ-032 With CLKS_PER_BIT=16 and full=0, sending 0xA5 SHALL give one wr pulse, din=8'hA5, wr at t0+155, and busy low the cycle after wr.
REQ-033 Sending 0x00, 0xFF and 0x3C back-to-back SHALL give 3 wr pulses with din 00, FF, 3C in order and no flags.
REQ-034 Sending 0x5A with full=1 SHALL give no wr, overrun=1 and din unchanged; err_clr for 1 cycle SHALL then give overrun=0.
REQ-035 Sending 0x81 with the stop bit low, then rx held low for 40 cycles, SHALL give frame_err=1, no wr, and busy held until rx returns high.
REQ-036 A 5-cycle rx low glitch SHALL give no wr, no flags, and busy back to 0 after the START sample.
REQ-037 rst pulsed during DATA bit 4 SHALL give no wr for that frame; the next frame, 0xC3, SHALL be received correctly.
